// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate datapath; purely combinational.
// Non-shift ops pass q through with a zero shifted-out bit.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_op,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  always_comb begin
    o_q    = i_q;
    o_sout = 1'b0;
    case (i_op)
      MODE_SHL: begin
        o_q    = {i_q[WIDTH-2:0], i_sin};
        o_sout = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q    = {i_sin, i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      MODE_ROTL: begin
        o_q    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_sout = i_q[WIDTH-1];
      end
      MODE_ROTR: begin
        o_q    = {i_q[0], i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      MODE_ASR: begin
        o_q    = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      default: begin
        o_q    = i_q;
        o_sout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_ce.sv
// Universal shift register with clock enable, async clear and an automatic
// multi-position mode (start -> busy for amt shifts -> one-cycle done).
module shift_reg_ce
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;

  logic [CNT_W-1:0] w_amt;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_sout;

  assign w_amt = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

  // The latched op drives the datapath during a sequence so mode changes are ignored.
  assign w_op = (r_state == ST_SHIFT) ? r_op : mode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_op   (w_op),
    .i_sin  (sin),
    .o_q    (w_step_q),
    .o_sout (w_step_sout)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= MODE_HOLD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ce) begin
            if (start && is_shift_mode(mode) && (w_amt != '0)) begin
              r_op    <= mode;
              r_cnt   <= w_amt;
              r_state <= ST_SHIFT;
            end else if (mode == MODE_LOAD) begin
              r_q    <= d;
              r_sout <= 1'b0;
            end else if (is_shift_mode(mode)) begin
              r_q    <= w_step_q;
              r_sout <= w_step_sout;
            end
          end
        end
        ST_SHIFT: begin
          if (ce) begin
            r_q    <= w_step_q;
            r_sout <= w_step_sout;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_reg_ce.sv
// Scoreboard bench for shift_reg_ce (WIDTH=8): stimulus queues expected state per edge,
// a monitor pops and compares after each clock edge or clear assertion.
module tb_shift_reg_ce;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             ce = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] d = '0;
  logic             sin = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] amt = '0;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_reg_ce #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .ce    (ce),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .start (start),
    .amt   (amt),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #10 clk = ~clk;

  // Monitor: one expected entry is consumed per clock edge or clear assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge clr);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (q !== e.q || sout !== e.sout || busy !== e.busy || done !== e.done) begin
          n_bad++;
          $display("FAIL %s: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%b busy=%b done=%b",
                   e.name, q, sout, busy, done, e.q, e.sout, e.busy, e.done);
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [2:0] m, input logic [7:0] dd,
                       input logic s, input logic st, input logic [3:0] a);
    @(negedge clk);
    ce = c; mode = m; d = dd; sin = s; start = st; amt = a;
  endtask

  task automatic expect_st(input string nm, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
    exp_t e;
    e.name = nm; e.q = eq; e.sout = es; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
  endtask

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROTL = 3'b100, ROTR = 3'b101, ASR = 3'b110;

  logic [7:0] asr_q [8] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};

  initial begin
    clr = 1'b1;
    // 1. Reset and clear
    drive(1, LOAD, 8'hFF, 0, 0, 0); expect_st("clr_load_ff", 8'h00, 0, 0, 0);
    drive(1, LOAD, 8'hA5, 0, 0, 0); clr = 1'b0; expect_st("load_a5", 8'hA5, 0, 0, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0);
    #5; expect_st("async_clr", 8'h00, 0, 0, 0); clr = 1'b1;
    drive(1, HOLD, 8'h00, 0, 0, 0); clr = 1'b0;

    // 2. Single-step and ce gating
    drive(1, LOAD, 8'hA5, 0, 0, 0); expect_st("load_a5_b", 8'hA5, 0, 0, 0);
    drive(1, SHL,  8'h00, 1, 0, 0); expect_st("shl_sin1",  8'h4B, 1, 0, 0);
    drive(1, ROTR, 8'h00, 0, 0, 0); expect_st("rotr",      8'hA5, 1, 0, 0);
    drive(1, LOAD, 8'h80, 0, 0, 0); expect_st("load_80",   8'h80, 0, 0, 0);
    drive(1, ASR,  8'h00, 0, 0, 0); expect_st("asr_80",    8'hC0, 0, 0, 0);
    drive(0, LOAD, 8'h3C, 0, 0, 0); expect_st("ce_low",    8'hC0, 0, 0, 0);

    // 3. Automatic rotate
    drive(1, LOAD, 8'h81, 0, 0, 0); expect_st("load_81",  8'h81, 0, 0, 0);
    drive(1, ROTL, 8'h00, 0, 1, 3); expect_st("rotl_e0",  8'h81, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotl_e1",  8'h03, 1, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotl_e2",  8'h06, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotl_e3",  8'h0C, 0, 0, 1);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotl_idle", 8'h0C, 0, 0, 0);

    // 4. Stall and ignore
    drive(1, LOAD, 8'hF0, 0, 0, 0); expect_st("load_f0",   8'hF0, 0, 0, 0);
    drive(1, SHR,  8'h00, 0, 1, 4); expect_st("shr_e0",    8'hF0, 0, 1, 0);
    drive(1, LOAD, 8'hFF, 0, 1, 1); expect_st("shr_s1",    8'h78, 0, 1, 0);
    drive(0, ROTL, 8'h55, 1, 1, 7); expect_st("stall_1",   8'h78, 0, 1, 0);
    drive(0, LOAD, 8'hAA, 1, 0, 2); expect_st("stall_2",   8'h78, 0, 1, 0);
    drive(1, ASR,  8'h11, 0, 1, 3); expect_st("shr_s2",    8'h3C, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("shr_s3",    8'h1E, 0, 1, 0);
    drive(1, SHL,  8'h00, 0, 0, 0); expect_st("shr_s4",    8'h0F, 0, 0, 1);
    drive(0, SHL,  8'h00, 1, 1, 2); expect_st("done_start", 8'h0F, 0, 0, 0);

    // 5. Boundaries
    drive(1, SHL,  8'h00, 0, 1, 0); expect_st("amt0_shl",  8'h1E, 0, 0, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("amt0_idle", 8'h1E, 0, 0, 0);
    drive(1, LOAD, 8'h80, 0, 0, 0); expect_st("load_80_b", 8'h80, 0, 0, 0);
    drive(1, ASR,  8'h00, 0, 1, 15); expect_st("asr15_e0", 8'h80, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, HOLD, 8'h00, 0, 0, 0);
      expect_st($sformatf("asr15_s%0d", i + 1), asr_q[i], (i == 7), (i != 7), (i == 7));
    end
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("asr15_idle", 8'hFF, 1, 0, 0);
    drive(1, LOAD, 8'h55, 0, 0, 0); expect_st("load_55",   8'h55, 0, 0, 0);
    drive(1, SHL,  8'h00, 1, 1, 1); expect_st("amt1_e0",   8'h55, 0, 1, 0);
    drive(1, HOLD, 8'h00, 1, 0, 0); expect_st("amt1_e1",   8'hAB, 0, 0, 1);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("amt1_idle", 8'hAB, 0, 0, 0);

    // 6. Clear mid-operation, then a fresh run
    drive(1, LOAD, 8'h0F, 0, 0, 0); expect_st("load_0f",   8'h0F, 0, 0, 0);
    drive(1, ROTR, 8'h00, 0, 1, 4); expect_st("rotr_e0",   8'h0F, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotr_e1",   8'h87, 1, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rotr_e2",   8'hC3, 1, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0);
    #5; expect_st("clr_mid", 8'h00, 0, 0, 0); clr = 1'b1;
    drive(1, ROTR, 8'h00, 0, 1, 4); expect_st("clr_held",  8'h00, 0, 0, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); clr = 1'b0; expect_st("clr_rel", 8'h00, 0, 0, 0);
    drive(1, LOAD, 8'h01, 0, 0, 0); expect_st("load_01",   8'h01, 0, 0, 0);
    drive(1, ROTL, 8'h00, 0, 1, 2); expect_st("rerun_e0",  8'h01, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rerun_e1",  8'h02, 0, 1, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rerun_e2",  8'h04, 0, 0, 1);
    drive(1, HOLD, 8'h00, 0, 0, 0); expect_st("rerun_idle", 8'h04, 0, 0, 0);

    drive(1, HOLD, 8'h00, 0, 0, 0);
    drive(1, HOLD, 8'h00, 0, 0, 0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
